// File: rtl/maxpool2x2_ctrl.sv
// rtl/maxpool2x2_ctrl.sv - 2x2 stride-2 max-pool sequencer for one raster-order channel.
module maxpool2x2_ctrl #(
    parameter int DATA_WIDHT = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [DATA_WIDHT-1:0] In_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_WIDHT-1:0] Out_Data,
    output logic                  Busy,
    output logic                  Done
);
    localparam int CW  = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LBN = IMG_WIDTH / 2;
    localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDHT-1:0] r_h;
    logic [DATA_WIDHT-1:0] r_out_data;
    logic                  r_out_valid;
    logic [DATA_WIDHT-1:0] r_lb [0:(1<<LW)-1];

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_load;
    logic [LW-1:0]         w_lb_idx;
    logic [DATA_WIDHT-1:0] w_h;

    // Ties return the first operand.
    function automatic logic [DATA_WIDHT-1:0] f_max(input logic [DATA_WIDHT-1:0] a,
                                                     input logic [DATA_WIDHT-1:0] b);
        if (SIGNED != 0)
            return ($signed(a) >= $signed(b)) ? a : b;
        return (a >= b) ? a : b;
    endfunction

    // Only the window-completing pixel needs the output register, so only it stalls.
    assign w_in_ready = (r_state == S_RUN) &&
                        !(r_row[0] && r_col[0] && r_out_valid && !Out_Ready);
    assign w_accept   = In_Valid && w_in_ready;
    assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_lb_idx   = LW'(r_col >> 1);
    assign w_h        = f_max(r_h, In_Data);
    assign w_load     = w_accept && r_col[0] && r_row[0];

    assign In_Ready  = w_in_ready;
    assign Out_Valid = r_out_valid;
    assign Out_Data  = r_out_data;
    assign Busy      = (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        Done   = 1'b0;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_RUN;
            S_RUN:   if (w_accept && w_col_last && w_row_last) w_next = S_FLUSH;
            S_FLUSH: begin
                if (!r_out_valid || Out_Ready) begin
                    Done   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_h         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && Start) begin
                r_col <= '0;
                r_row <= '0;
            end
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (!r_col[0])
                    r_h <= In_Data;
            end
            if (w_load) begin
                r_out_data  <= f_max(r_lb[w_lb_idx], w_h);
                r_out_valid <= 1'b1;
            end else if (Out_Ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Line buffer holds the even row's horizontal maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept && r_col[0] && !r_row[0])
            r_lb[w_lb_idx] <= w_h;
    end
endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// tb/tb_maxpool2x2_ctrl.sv - directed self-checking bench for maxpool2x2_ctrl.
module tb_maxpool2x2_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, iv, ordy;
    logic [7:0] id;
    logic       a_ir, a_ov, a_busy, a_done;
    logic [7:0] a_od;
    logic       b_ir, b_ov, b_busy, b_done;
    logic [7:0] b_od;
    logic       c_start, c_iv, c_ordy;
    logic [7:0] c_id;
    logic       c_ir, c_ov, c_busy, c_done;
    logic [7:0] c_od;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_a = 0, done_c = 0;
    int a_done_cyc = 0, a_last_acc = 0, a_last_xfer = 0;
    logic [7:0] qa[$], qb[$], qc[$];
    logic [7:0] pix [64];
    logic [7:0] ex  [16];
    logic [7:0] exb [16];

    always #5 clk = ~clk;

    maxpool2x2_ctrl #(.DATA_WIDHT(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED(0)) dut_a (
        .clk(clk), .rst(rst), .Start(start), .In_Valid(iv), .In_Ready(a_ir), .In_Data(id),
        .Out_Valid(a_ov), .Out_Ready(ordy), .Out_Data(a_od), .Busy(a_busy), .Done(a_done));
    maxpool2x2_ctrl #(.DATA_WIDHT(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED(1)) dut_b (
        .clk(clk), .rst(rst), .Start(start), .In_Valid(iv), .In_Ready(b_ir), .In_Data(id),
        .Out_Valid(b_ov), .Out_Ready(ordy), .Out_Data(b_od), .Busy(b_busy), .Done(b_done));
    maxpool2x2_ctrl #(.DATA_WIDHT(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .SIGNED(0)) dut_c (
        .clk(clk), .rst(rst), .Start(c_start), .In_Valid(c_iv), .In_Ready(c_ir), .In_Data(c_id),
        .Out_Valid(c_ov), .Out_Ready(c_ordy), .Out_Data(c_od), .Busy(c_busy), .Done(c_done));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (iv && a_ir) a_last_acc = cyc;
        if (a_ov && ordy) begin qa.push_back(a_od); a_last_xfer = cyc; end
        if (b_ov && ordy) qb.push_back(b_od);
        if (c_ov && c_ordy) qc.push_back(c_od);
        if (a_done) begin done_a++; a_done_cyc = cyc; end
        if (c_done) done_c++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int sel);
        @(posedge clk); #1;
        if (sel == 0) start = 1'b1; else c_start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        c_start = 1'b0;
    endtask

    task automatic feed(input int sel, input int n, input int maxgap);
        int  g;
        bit  ok;
        logic rdy;
        for (int i = 0; i < n; i++) begin
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            for (int k = 0; k < g; k++) begin
                if (sel == 0) iv = 1'b0; else c_iv = 1'b0;
                @(posedge clk); #1;
            end
            if (sel == 0) begin iv = 1'b1; id = pix[i]; end
            else begin c_iv = 1'b1; c_id = pix[i]; end
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                rdy = (sel == 0) ? a_ir : c_ir;
                @(posedge clk); #1;
                if (rdy) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                chk("feed_accept_timeout", 32'(ok), 32'd1);
                break;
            end
        end
        iv   = 1'b0;
        c_iv = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int base, input string tag);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (((sel == 0) ? done_a : done_c) > base) begin seen = 1'b1; break; end
        end
        chk(tag, 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_a4(input string tag);
        chk({tag, "_count"}, qa.size(), 4);
        for (int i = 0; i < 4; i++) chk({tag, "_data"}, qa[i], ex[i]);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        ex[0] = 8'd5; ex[1] = 8'd7; ex[2] = 8'd13; ex[3] = 8'd15;
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; iv = 1'b0; id = '0; ordy = 1'b1;
        c_start = 1'b0; c_iv = 1'b0; c_id = '0; c_ordy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", a_ir, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_data", a_od, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        @(posedge clk); #1 rst = 1'b0;

        // T1: ramp 0..15 with free-flowing output
        load_ramp();
        qa.delete(); base = done_a;
        pulse_start(0);
        chk("t1_busy", a_busy, 1);
        feed(0, 16, 0);
        wait_done(0, base, "t1_done_seen");
        check_a4("t1");
        chk("t1_done_after_last_accept", 32'(a_done_cyc - a_last_acc), 1);
        chk("t1_done_with_last_xfer", 32'(a_done_cyc), 32'(a_last_xfer));
        chk("t1_one_done", 32'(done_a - base), 1);
        chk("t1_idle_busy", a_busy, 0);

        // T2: signed vs unsigned compare on the same stream
        pix[0] = 8'hFF; pix[1] = 8'hF8; pix[2] = 8'h03; pix[3] = 8'hFE;
        for (int i = 4; i < 16; i++) pix[i] = 8'hFB;
        ex[0] = 8'hFF; ex[1] = 8'hFE; ex[2] = 8'hFB; ex[3] = 8'hFB;
        exb[0] = 8'hFF; exb[1] = 8'h03; exb[2] = 8'hFB; exb[3] = 8'hFB;
        qa.delete(); qb.delete(); base = done_a;
        pulse_start(0);
        feed(0, 16, 0);
        wait_done(0, base, "t2_done_seen");
        check_a4("t2_unsigned");
        chk("t2_signed_count", qb.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_signed_data", qb[i], exb[i]);

        // T3: back-pressure at the first output
        load_ramp();
        qa.delete(); base = done_a; ordy = 1'b0;
        pulse_start(0);
        fork
            feed(0, 16, 0);
            begin
                bit found;
                found = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (a_ov) begin found = 1'b1; break; end
                end
                chk("t3_first_valid", 32'(found), 1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("t3_hold_data", a_od, 8'd5);
                    chk("t3_hold_valid", a_ov, 1);
                end
                chk("t3_in_ready_r1c3", a_ir, 0);
                @(posedge clk); #1 ordy = 1'b1;
            end
        join
        wait_done(0, base, "t3_done_seen");
        check_a4("t3");

        // T4: Start pulse mid-frame is ignored
        qa.delete(); base = done_a;
        pulse_start(0);
        fork
            feed(0, 16, 0);
            begin
                repeat (6) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        wait_done(0, base, "t4_done_seen");
        check_a4("t4");
        chk("t4_one_done", 32'(done_a - base), 1);
        chk("t4_idle_busy", a_busy, 0);

        // T5: reset mid-frame with an output pending
        ordy = 1'b0;
        pulse_start(0);
        feed(0, 6, 0);
        @(negedge clk);
        chk("t5_pending_valid", a_ov, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_out_valid", a_ov, 0);
        chk("t5_rst_busy", a_busy, 0);
        chk("t5_rst_in_ready", a_ir, 0);
        @(posedge clk); #1;
        qa.delete(); ordy = 1'b1; base = done_a;
        pulse_start(0);
        feed(0, 16, 0);
        wait_done(0, base, "t5_done_seen");
        check_a4("t5");

        // T6: two 8x8 frames, random gaps, reference max model
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) pix[i] = 8'($urandom_range(0, 255));
            for (int w = 0; w < 16; w++) begin
                int r, cc;
                logic [7:0] m;
                r = w / 4; cc = w % 4;
                m = pix[(2*r)*8 + 2*cc];
                if (pix[(2*r)*8 + 2*cc + 1]   > m) m = pix[(2*r)*8 + 2*cc + 1];
                if (pix[(2*r+1)*8 + 2*cc]     > m) m = pix[(2*r+1)*8 + 2*cc];
                if (pix[(2*r+1)*8 + 2*cc + 1] > m) m = pix[(2*r+1)*8 + 2*cc + 1];
                ex[w] = m;
            end
            qc.delete(); base = done_c;
            pulse_start(1);
            fork
                feed(1, 64, 2);
                begin
                    for (int k = 0; k < 3000 && done_c == base; k++) begin
                        @(posedge clk); #1;
                        c_ordy = (f == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    end
                    c_ordy = 1'b1;
                end
            join
            wait_done(1, base, "t6_done_seen");
            chk("t6_count", qc.size(), 16);
            for (int w = 0; w < 16; w++) chk("t6_data", qc[w], ex[w]);
            chk("t6_one_done", 32'(done_c - base), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
